// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate-selector sweep checker and its golden model.
package gate_sweep_pkg;

    localparam int NUM_VEC = 32;
    localparam int VEC_W   = 5;
    localparam int ERR_W   = 6;

    // Function codes driven on sel; codes 6 and 7 both select NAND.
    localparam logic [2:0] OP_NOT_A     = 3'd0;
    localparam logic [2:0] OP_NOR2      = 3'd1;
    localparam logic [2:0] OP_AND2      = 3'd2;
    localparam logic [2:0] OP_OR2       = 3'd3;
    localparam logic [2:0] OP_XOR2      = 3'd4;
    localparam logic [2:0] OP_XNOR2     = 3'd5;
    localparam logic [2:0] OP_NAND2_ALT = 3'd6;
    localparam logic [2:0] OP_NAND2     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Operand/result bus between the sweep checker (master) and the gate selector under test (slave).
interface gate_sweep_checker_if;

    logic       dut_a;
    logic       dut_b;
    logic [2:0] dut_sel;
    logic       dut_out;

    modport master (output dut_a, output dut_b, output dut_sel, input dut_out);
    modport slave  (input dut_a, input dut_b, input dut_sel, output dut_out);

endinterface

// File: rtl/gate_golden_model.sv
// Combinational reference for the 8-function gate selector; reusable by other sweep checkers.
module gate_golden_model
    import gate_sweep_pkg::*;
(
    input  logic [2:0] sel,
    input  logic       a,
    input  logic       b,
    output logic       expected
);

    always_comb begin
        // NOTE: default assigned first so no path leaves expected unassigned (no latch).
        expected = 1'b0;
        case (sel)
            OP_NOT_A: expected = ~a;
            OP_NOR2:  expected = ~(a | b);
            OP_AND2:  expected = a & b;
            OP_OR2:   expected = a | b;
            OP_XOR2:  expected = a ^ b;
            OP_XNOR2: expected = ~(a ^ b);
            default:  expected = ~(a & b);
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all 32 {sel,a,b} vectors into a gate selector, samples its output after a settle
// interval and accumulates mismatch count and first failing vector.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    gate_sweep_checker_if.master sel_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [VEC_W-1:0]     first_fail_vec,
    output logic                 fail_valid
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t             r_state;
    state_t             w_next;
    logic [VEC_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_settle_cnt;
    logic               r_dut_a;
    logic               r_dut_b;
    logic [2:0]         r_dut_sel;
    logic [ERR_W-1:0]   r_err_count;
    logic [VEC_W-1:0]   r_first_fail_vec;
    logic               r_fail_valid;
    logic               w_expected;
    logic               w_mismatch;
    logic               w_start_ok;
    logic               w_last;

    gate_golden_model u_golden (
        .sel      (r_idx[4:2]),
        .a        (r_idx[1]),
        .b        (r_idx[0]),
        .expected (w_expected)
    );

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_idx == VEC_W'(NUM_VEC - 1));
    assign w_mismatch = (r_state == ST_SAMPLE) && (sel_bus.dut_out != w_expected);

    // NOTE: asynchronous active-low reset lives in the sensitivity list of every state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_DRIVE;
            ST_DRIVE:         w_next = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE:        if (r_settle_cnt == SETTLE_LAST) w_next = ST_SAMPLE;
            ST_SAMPLE: begin
                if (w_last || (w_mismatch && STOP_ON_FAIL)) w_next = ST_DONE;
                else                                        w_next = ST_DRIVE;
            end
            default:          w_next = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx            <= '0;
            r_settle_cnt     <= '0;
            r_dut_a          <= 1'b0;
            r_dut_b          <= 1'b0;
            r_dut_sel        <= '0;
            r_err_count      <= '0;
            r_first_fail_vec <= '0;
            r_fail_valid     <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_idx            <= '0;
                r_err_count      <= '0;
                r_first_fail_vec <= '0;
                r_fail_valid     <= 1'b0;
            end
            if (r_state == ST_DRIVE) {r_dut_sel, r_dut_a, r_dut_b} <= r_idx;
            if (r_state == ST_SETTLE)
                r_settle_cnt <= (r_settle_cnt == SETTLE_LAST) ? '0 : r_settle_cnt + 1'b1;
            if (r_state == ST_SAMPLE) begin
                if (w_mismatch) begin
                    r_err_count <= r_err_count + 1'b1;
                    if (!r_fail_valid) begin
                        r_first_fail_vec <= r_idx;
                        r_fail_valid     <= 1'b1;
                    end
                end
                if (w_next == ST_DRIVE) r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign sel_bus.dut_a   = r_dut_a;
    assign sel_bus.dut_b   = r_dut_b;
    assign sel_bus.dut_sel = r_dut_sel;

    assign busy           = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done           = (r_state == ST_DONE);
    assign pass           = done && (r_err_count == '0);
    assign err_count      = r_err_count;
    assign first_fail_vec = r_first_fail_vec;
    assign fail_valid     = r_fail_valid;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: three checker instances (defaults, STOP_ON_FAIL=1, SETTLE_CYCLES=0) each
// drive a behavioural selector with selectable faults; a monitor checks every completed sweep.
module tb_gate_sweep_checker;
    import gate_sweep_pkg::*;

    localparam int N_INST = 3;

    typedef enum int {F_IDEAL, F_STUCK0, F_STUCK1, F_INV_SEL5} fault_t;

    typedef struct {
        string name;
        int    inst;
        int    start_cyc;
        int    latency;
        int    err;
        int    ffv;
        int    fv;
        int    pass_v;
    } exp_t;

    exp_t exp_q[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_INST-1:0] start_r = '0;
    logic [N_INST-1:0] busy_w;
    logic [N_INST-1:0] done_w;
    logic [N_INST-1:0] pass_w;
    logic [N_INST-1:0] fv_w;
    logic [5:0]        err_w [N_INST];
    logic [4:0]        ffv_w [N_INST];
    logic [4:0]        vec_w [N_INST];
    fault_t            fault_mode = F_IDEAL;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Truth table per sel, bit index {a,b}.
    function automatic logic sel_model(fault_t m, logic [4:0] v);
        logic [3:0] row;
        logic       good;
        case (v[4:2])
            3'd0:    row = 4'b0011;
            3'd1:    row = 4'b0001;
            3'd2:    row = 4'b1000;
            3'd3:    row = 4'b1110;
            3'd4:    row = 4'b0110;
            3'd5:    row = 4'b1001;
            default: row = 4'b0111;
        endcase
        good = row[v[1:0]];
        case (m)
            F_STUCK0:   return 1'b0;
            F_STUCK1:   return 1'b1;
            F_INV_SEL5: return (v[4:2] == 3'd5) ? ~good : good;
            default:    return good;
        endcase
    endfunction

    for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
        localparam int ST  = (gi == 2) ? 0 : 1;
        localparam bit SOF = (gi == 1);
        gate_sweep_checker_if bus_if ();
        assign bus_if.dut_out = sel_model(fault_mode, {bus_if.dut_sel, bus_if.dut_a, bus_if.dut_b});
        assign vec_w[gi] = {bus_if.dut_sel, bus_if.dut_a, bus_if.dut_b};
        gate_sweep_checker #(.SETTLE_CYCLES(ST), .STOP_ON_FAIL(SOF)) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start_r[gi]),
            .sel_bus        (bus_if),
            .busy           (busy_w[gi]),
            .done           (done_w[gi]),
            .pass           (pass_w[gi]),
            .err_count      (err_w[gi]),
            .first_fail_vec (ffv_w[gi]),
            .fail_valid     (fv_w[gi])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: on each done rising edge, pop the oldest expectation and compare.
    initial begin
        logic [N_INST-1:0] prev;
        exp_t              e;
        prev = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_INST; i++) begin
                if (done_w[i] && !prev[i]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected done inst", i, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, " inst"},       i,                   e.inst);
                        check({e.name, " latency"},    cyc - e.start_cyc,   e.latency);
                        check({e.name, " err_count"},  int'(err_w[i]),      e.err);
                        check({e.name, " first_fail"}, int'(ffv_w[i]),      e.ffv);
                        check({e.name, " fail_valid"}, int'(fv_w[i]),       e.fv);
                        check({e.name, " pass"},       int'(pass_w[i]),     e.pass_v);
                        check({e.name, " busy"},       int'(busy_w[i]),     0);
                    end
                end
            end
            prev = done_w;
        end
    end

    task automatic pulse_start(input int inst);
        @(negedge clk);
        start_r[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_r[inst] = 1'b0;
    endtask

    task automatic issue(input int inst, input fault_t m, input string name,
                         input int lat, input int err, input int ffv, input int fv, input int pv);
        exp_t e;
        fault_mode = m;
        pulse_start(inst);
        e.name = name;  e.inst = inst;  e.start_cyc = cyc;  e.latency = lat;
        e.err  = err;   e.ffv  = ffv;   e.fv = fv;          e.pass_v  = pv;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int inst, input string name);
        int n = 0;
        while (!done_w[inst] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done_w[inst]) check({name, " timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic run(input int inst, input fault_t m, input string name,
                       input int lat, input int err, input int ffv, input int fv, input int pv);
        issue(inst, m, name, lat, err, ffv, fv, pv);
        wait_done(inst, name);
    endtask

    task automatic check_zero(input int inst, input string tag);
        check({tag, " busy"},       int'(busy_w[inst]), 0);
        check({tag, " done"},       int'(done_w[inst]), 0);
        check({tag, " pass"},       int'(pass_w[inst]), 0);
        check({tag, " err_count"},  int'(err_w[inst]),  0);
        check({tag, " first_fail"}, int'(ffv_w[inst]),  0);
        check({tag, " fail_valid"}, int'(fv_w[inst]),   0);
        check({tag, " dut_vec"},    int'(vec_w[inst]),  0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_zero(0, "in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero(0, "after_reset");

        run(0, F_IDEAL, "ideal", 96, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("hold done",    int'(done_w[0]), 1);
        check("hold dut_vec", int'(vec_w[0]),  31);
        check("hold pass",    int'(pass_w[0]), 1);

        run(0, F_STUCK0,   "stuck0",   96, 17, 0,  1, 0);
        run(0, F_STUCK1,   "stuck1",   96, 15, 2,  1, 0);
        run(0, F_INV_SEL5, "inv_sel5", 96, 4,  20, 1, 0);

        run(1, F_STUCK0, "sof_stuck0", 3,  1, 0, 1, 0);
        run(1, F_STUCK1, "sof_stuck1", 9,  1, 2, 1, 0);
        run(1, F_IDEAL,  "sof_ideal",  96, 0, 0, 0, 1);

        run(2, F_IDEAL,  "settle0_ideal",  64, 0,  0, 0, 1);
        run(2, F_STUCK1, "settle0_stuck1", 64, 15, 2, 1, 0);

        // Abort a stuck-at-0 sweep once vector 10 is on the bus.
        fault_mode = F_STUCK0;
        pulse_start(0);
        n = 0;
        while (vec_w[0] != 5'd10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach vec10", int'(vec_w[0]), 10);
        check("err before reset", int'(err_w[0]), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, F_IDEAL, "post_reset", 96, 0, 0, 0, 1);
        repeat (5) @(negedge clk);
        check("busy before 2nd start", int'(busy_w[0]), 1);
        pulse_start(0);
        wait_done(0, "post_reset");

        check("scoreboard empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
